// File: rtl/led_sequence_controller.sv
// rtl/led_sequence_controller.sv - LEDG slot sequencer with start/stop/pause control; optional LED_SEQ_BOUNCE_EN ping-pong stepping
module led_sequence_controller #(
    parameter int TICKS_PER_STEP = 20000000,
    parameter int NUM_SLOTS      = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic       step_pulse,
    output logic [7:0] LEDG,
    output logic [9:0] LEDR
);

    localparam int              CW   = $clog2(TICKS_PER_STEP);
    localparam logic [CW-1:0]   TC   = CW'(TICKS_PER_STEP - 1);
    localparam logic [2:0]      LAST = 3'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic [2:0]      slot;
    logic [3:0]      pass_cnt;
    logic [1:0]      mode_q;
    logic [2:0]      slot_nxt;
    logic            wrap;
    logic            count_en;
    logic            at_tc;
`ifdef LED_SEQ_BOUNCE_EN
    logic            dir;       // 0 = up, 1 = down
    logic            dir_nxt;
`endif

    // LEDG pattern for a slot under a given mode
    function automatic logic [7:0] pattern(input logic [2:0] s, input logic [1:0] m);
        case (m)
            2'b00:   pattern = 8'h80 >> s;
            2'b01:   pattern = ~(8'hFF >> ({1'b0, s} + 4'd1));
            2'b10:   pattern = s[0] ? 8'h00 : 8'hFF;
            default: pattern = s[0] ? 8'h55 : 8'hAA;
        endcase
    endfunction

    // Counting happens in RUN, and on the edge that resumes from PAUSE, unless stop/start override
    assign count_en = !stop && !start &&
                      (((state == S_RUN) && !pause) || ((state == S_PAUSE) && pause));
    assign at_tc    = (tick_cnt == TC);

    // Next slot and pass-wrap indication for the current stepping direction
    always_comb begin
        slot_nxt = slot + 3'd1;
        wrap     = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
        dir_nxt  = dir;
        if (!dir) begin
            if (slot == LAST) begin
                slot_nxt = LAST - 3'd1;
                dir_nxt  = 1'b1;
            end
        end else begin
            if (slot == 3'd0) begin
                slot_nxt = 3'd1;
                dir_nxt  = 1'b0;
                wrap     = 1'b1;
            end else begin
                slot_nxt = slot - 3'd1;
            end
        end
`else
        if (slot == LAST) begin
            slot_nxt = 3'd0;
            wrap     = 1'b1;
        end
`endif
    end

    // Control FSM, tick counter, slot stepping and registered LED outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            slot       <= 3'd0;
            pass_cnt   <= 4'd0;
            mode_q     <= 2'b00;
            step_pulse <= 1'b0;
            LEDG       <= 8'h00;
`ifdef LED_SEQ_BOUNCE_EN
            dir        <= 1'b0;
`endif
        end else begin
            step_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    slot     <= 3'd0;
                    LEDG     <= 8'h00;
                    if (!stop && start) begin
                        state  <= S_RUN;
                        mode_q <= mode;
                        LEDG   <= pattern(3'd0, mode);
`ifdef LED_SEQ_BOUNCE_EN
                        dir    <= 1'b0;
`endif
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (stop) begin
                        state    <= S_IDLE;
                        tick_cnt <= '0;
                        slot     <= 3'd0;
                        LEDG     <= 8'h00;
`ifdef LED_SEQ_BOUNCE_EN
                        dir      <= 1'b0;
`endif
                    end else if (start) begin
                        state    <= S_RUN;
                        tick_cnt <= '0;
                        slot     <= 3'd0;
                        mode_q   <= mode;
                        LEDG     <= pattern(3'd0, mode);
`ifdef LED_SEQ_BOUNCE_EN
                        dir      <= 1'b0;
`endif
                    end else if (pause) begin
                        state <= (state == S_RUN) ? S_PAUSE : S_RUN;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= '0;
                    slot     <= 3'd0;
                    LEDG     <= 8'h00;
                end
            endcase

            // Slot advance lands on the same edge as step_pulse and the new LEDG value
            if (count_en) begin
                if (at_tc) begin
                    tick_cnt   <= '0;
                    slot       <= slot_nxt;
                    LEDG       <= pattern(slot_nxt, mode_q);
                    step_pulse <= 1'b1;
                    if (wrap) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end
`ifdef LED_SEQ_BOUNCE_EN
                    dir        <= dir_nxt;
`endif
                end else begin
                    tick_cnt <= tick_cnt + CW'(1);
                end
            end
        end
    end

    assign LEDR = {pass_cnt, step_pulse, state, slot};

endmodule
